// File: rtl/dm_sized_port.sv
// Byte/half/word big-endian data memory with a valid/ready request port and a one-entry registered response slot.
// Optional misalignment faulting is enabled by defining DM_ALIGN_CHECK_EN.
module dm_sized_port #(
    parameter int unsigned MEM_BYTES = 32,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned IDX_W = $clog2(MEM_BYTES);

    logic [7:0]        mem_q [MEM_BYTES];
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic [2:0]        n_s;
    logic              size_bad_s;
    logic              misalign_s;
    logic              range_bad_s;
    logic              fault_s;
    logic              accept_s;
    logic              store_en_s;
    logic [ADDR_W:0]   last_s;
    logic [IDX_W-1:0]  idx_s;
    logic [5:0]        sh_s;
    logic [31:0]       rd_raw_s;
    logic [31:0]       wr_aligned_s;
    logic [IDX_W-1:0]  off_s [MEM_BYTES];
    logic              we_s  [MEM_BYTES];
    logic [7:0]        wd_s  [MEM_BYTES];

    function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] size, input logic uns);
        logic [31:0] r;
        case (size)
            2'b00:   r = {{24{~uns & v[7]}}, v[7:0]};
            2'b01:   r = {{16{~uns & v[15]}}, v[15:0]};
            default: r = v;
        endcase
        return r;
    endfunction

    // Decode access size into a byte count.
    always_comb begin
        size_bad_s = 1'b0;
        case (req_size)
            2'b00:   n_s = 3'd1;
            2'b01:   n_s = 3'd2;
            2'b10:   n_s = 3'd4;
            default: begin
                n_s        = 3'd4;
                size_bad_s = 1'b1;
            end
        endcase
    end

`ifdef DM_ALIGN_CHECK_EN
    // Natural-alignment check for half and word accesses.
    always_comb begin
        if (req_size == 2'b01) begin
            misalign_s = req_addr[0];
        end else if (req_size == 2'b10) begin
            misalign_s = (req_addr[1:0] != 2'b00);
        end else begin
            misalign_s = 1'b0;
        end
    end
`else
    assign misalign_s = 1'b0;
`endif

    // One extra bit on the last-byte address keeps accesses near the top of the address space from wrapping.
    assign last_s      = {1'b0, req_addr} + (ADDR_W+1)'(n_s - 3'd1);
    assign range_bad_s = (last_s >= (ADDR_W+1)'(MEM_BYTES));
    assign fault_s     = size_bad_s | range_bad_s | misalign_s;
    assign req_ready   = ~rsp_valid_q | rsp_ready;
    assign accept_s    = req_valid & req_ready;
    assign store_en_s  = accept_s & req_we & ~fault_s;
    assign idx_s       = req_addr[IDX_W-1:0];
    assign sh_s        = 6'd32 - {n_s, 3'b000};
    assign wr_aligned_s = req_wdata << sh_s;

    // Gather four bytes starting at the address, MSB first; unused tail bytes are shifted out.
    always_comb begin
        rd_raw_s = 32'h0000_0000;
        for (int k = 0; k < 4; k++) begin
            rd_raw_s[31-8*k -: 8] = mem_q[idx_s + IDX_W'(k)];
        end
    end

    // Per-byte write enables: a byte is written when its offset from the address is below the size.
    always_comb begin
        for (int i = 0; i < MEM_BYTES; i++) begin
            off_s[i] = IDX_W'(i) - idx_s;
            we_s[i]  = store_en_s & (int'(off_s[i]) < int'(n_s));
            wd_s[i]  = 8'(wr_aligned_s >> {2'd3 - off_s[i][1:0], 3'b000});
        end
    end

    // Storage array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_BYTES; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < MEM_BYTES; i++) begin
                if (we_s[i]) begin
                    mem_q[i] <= wd_s[i];
                end
            end
        end
    end

    // Response slot next state: load on accept, drop on consume, otherwise hold.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        if (accept_s) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = fault_s;
            if (fault_s || req_we) begin
                rsp_rdata_d = 32'h0000_0000;
            end else begin
                rsp_rdata_d = extend(rd_raw_s >> sh_s, req_size, req_unsigned);
            end
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end else begin
            rsp_valid_d = rsp_valid_q;
        end
    end

    // Response slot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0000_0000;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dm_sized_port.sv
// Directed bench for dm_sized_port (MEM_BYTES=32); expectations follow DM_ALIGN_CHECK_EN if defined.
module tb_dm_sized_port;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks;
    int errors;

    dm_sized_port #(.MEM_BYTES(32), .ADDR_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request accepted at the next posedge; response checked 1 ns later.
    task automatic xact(input string tag, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err);
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk({tag, ".valid"}, {31'd0, rsp_valid}, 32'd1);
        chk({tag, ".rdata"}, rsp_rdata, exp_rd);
        chk({tag, ".err"},   {31'd0, rsp_err},   {31'd0, exp_err});
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;
        rsp_ready    = 1'b1;
        #12;
        chk("rst.valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst.rdata", rsp_rdata, 32'd0);
        chk("rst.err",   {31'd0, rsp_err},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst.ready", {31'd0, req_ready}, 32'd1);

        // Word store/load and byte lane order
        xact("sw0",  1'b1, 2'b10, 1'b0, 32'd0, 32'h1122_3344, 32'h0000_0000, 1'b0);
        xact("lw0",  1'b0, 2'b10, 1'b0, 32'd0, 32'd0,         32'h1122_3344, 1'b0);
        xact("lb1",  1'b0, 2'b00, 1'b0, 32'd1, 32'd0,         32'h0000_0022, 1'b0);

        // Sign/zero extension
        xact("sb5",  1'b1, 2'b00, 1'b0, 32'd5, 32'hFFFF_FF80, 32'h0000_0000, 1'b0);
        xact("lb5",  1'b0, 2'b00, 1'b0, 32'd5, 32'd0,         32'hFFFF_FF80, 1'b0);
        xact("lbu5", 1'b0, 2'b00, 1'b1, 32'd5, 32'd0,         32'h0000_0080, 1'b0);
        xact("lhu4", 1'b0, 2'b01, 1'b1, 32'd4, 32'd0,         32'h0000_0080, 1'b0);
        xact("sh6",  1'b1, 2'b01, 1'b0, 32'd6, 32'h1234_8001, 32'h0000_0000, 1'b0);
        xact("lh6",  1'b0, 2'b01, 1'b0, 32'd6, 32'd0,         32'hFFFF_8001, 1'b0);
        xact("lhu6", 1'b0, 2'b01, 1'b1, 32'd6, 32'd0,         32'h0000_8001, 1'b0);

        // Range, size and wrap faults
        xact("sw28",  1'b1, 2'b10, 1'b0, 32'd28, 32'hA1B2_C3D4, 32'h0000_0000, 1'b0);
        xact("lw30",  1'b0, 2'b10, 1'b0, 32'd30, 32'd0,         32'h0000_0000, 1'b1);
        xact("sw29",  1'b1, 2'b10, 1'b0, 32'd29, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1);
        xact("lw28",  1'b0, 2'b10, 1'b0, 32'd28, 32'd0,         32'hA1B2_C3D4, 1'b0);
        xact("lb31",  1'b0, 2'b00, 1'b0, 32'd31, 32'd0,         32'hFFFF_FFD4, 1'b0);
        xact("lb32",  1'b0, 2'b00, 1'b0, 32'd32, 32'd0,         32'h0000_0000, 1'b1);
        xact("lhtop", 1'b0, 2'b01, 1'b0, 32'hFFFF_FFFF, 32'd0,  32'h0000_0000, 1'b1);
        xact("sz11",  1'b0, 2'b11, 1'b0, 32'd0,  32'd0,         32'h0000_0000, 1'b1);
        xact("sz11w", 1'b1, 2'b11, 1'b0, 32'd0,  32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        xact("lw0b",  1'b0, 2'b10, 1'b0, 32'd0,  32'd0,         32'h1122_3344, 1'b0);

        // Misaligned word
`ifdef DM_ALIGN_CHECK_EN
        xact("lw2",  1'b0, 2'b10, 1'b0, 32'd2, 32'd0, 32'h0000_0000, 1'b1);
`else
        xact("lw2",  1'b0, 2'b10, 1'b0, 32'd2, 32'd0, 32'h3344_0080, 1'b0);
`endif

        // Backpressure: slot holds, request stalls, then accepts as rsp_ready rises
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        xact("stall.lw0", 1'b0, 2'b10, 1'b0, 32'd0, 32'd0, 32'h1122_3344, 1'b0);
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b1;
        req_addr     = 32'd1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("stall.valid", {31'd0, rsp_valid}, 32'd1);
            chk("stall.rdata", rsp_rdata, 32'h1122_3344);
            chk("stall.ready", {31'd0, req_ready}, 32'd0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        chk("stall.ready_up", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("stall.next_valid", {31'd0, rsp_valid}, 32'd1);
        chk("stall.next_rdata", rsp_rdata, 32'h0000_0022);

        // Asynchronous reset with a pending response
        rsp_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.valid", {31'd0, rsp_valid}, 32'd0);
        chk("arst.rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        xact("arst.lw0",  1'b0, 2'b10, 1'b0, 32'd0,  32'd0, 32'h0000_0000, 1'b0);
        xact("arst.lw28", 1'b0, 2'b10, 1'b0, 32'd28, 32'd0, 32'h0000_0000, 1'b0);

        @(posedge clk);
        #1;
        chk("idle.valid", {31'd0, rsp_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
